// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single synchronous memory port (1-cycle read latency) with bus locking.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_wen,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic [1:0]    m0_size,
   input  logic          m0_lock,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,
   input  logic          m1_req,
   input  logic          m1_wen,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic [1:0]    m1_size,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   output logic          mem_en,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [1:0]    mem_size,
   input  logic [31:0]   mem_rdata,
   output logic          busy,
   output logic          lock_err
);
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, LOCKED} state_t;

   state_t          state_q, state_d;
   logic            lock_q, lock_d;
   logic            owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            lock_err_q, lock_err_d;
   logic [31:0]     rdata_q;
   logic            gnt0, gnt1, g_lock;
`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0]      last_grant_q;
`endif

   // Grant selection: open arbitration in IDLE, owner-only while locked, none while a read returns.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (state_q)
         IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
            if (m0_req && m1_req) begin
               gnt1 = last_grant_q[0];
               gnt0 = ~last_grant_q[0];
            end else begin
               gnt0 = m0_req;
               gnt1 = m1_req;
            end
`else
            gnt0 = m0_req;
            gnt1 = m1_req & ~m0_req;
`endif
         end
         LOCKED: begin
            gnt0 = m0_req & ~owner_q;
            gnt1 = m1_req & owner_q;
         end
         default: ;
      endcase
      if (rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   always_comb begin
      mem_en    = gnt0 | gnt1;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_size  = '0;
      g_lock    = 1'b0;
      if (gnt0) begin
         mem_wen   = m0_wen;
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_size  = m0_size;
         g_lock    = m0_lock;
      end else if (gnt1) begin
         mem_wen   = m1_wen;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_size  = m1_size;
         g_lock    = m1_lock;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_d     = lock_q;
      owner_d    = owner_q;
      cnt_d      = '0;
      lock_err_d = lock_err_q;
      unique case (state_q)
         IDLE: begin
            if (mem_en) begin
               owner_d = gnt1;
               lock_d  = g_lock;
               if (!mem_wen)    state_d = RD_WAIT;
               else if (g_lock) state_d = LOCKED;
            end
         end
         RD_WAIT: state_d = lock_q ? LOCKED : IDLE;
         LOCKED: begin
            if (mem_en) begin
               lock_d = g_lock;
               if (!mem_wen)     state_d = RD_WAIT;
               else if (!g_lock) state_d = IDLE;
            end else begin
               // Silent owner: count idle locked cycles and force release at the limit.
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CW'(LOCK_TIMEOUT)) begin
                  state_d    = IDLE;
                  lock_d     = 1'b0;
                  lock_err_d = 1'b1;
                  cnt_d      = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lock_q     <= 1'b0;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         lock_err_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         lock_q     <= lock_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         lock_err_q <= lock_err_d;
         if (state_q == RD_WAIT) rdata_q <= mem_rdata;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         last_grant_q <= 2'b00;
      else if (mem_en) last_grant_q <= {gnt1, gnt0};
   end
`endif

   // Read data is presented in the return cycle and held afterwards until the next read completes.
   always_comb begin
      m0_gnt    = gnt0;
      m1_gnt    = gnt1;
      m0_rvalid = (state_q == RD_WAIT) & ~owner_q;
      m1_rvalid = (state_q == RD_WAIT) & owner_q;
      m0_rdata  = (state_q == RD_WAIT) ? mem_rdata : rdata_q;
      m1_rdata  = m0_rdata;
      busy      = (state_q != IDLE) | lock_q;
      lock_err  = lock_err_q;
   end

endmodule
